mac_tile_engine: RTL and testbench

MAC_TILE_ENGINE -- requirements
Module: mac_tile_engine

---
 rtl/mac_tile_pkg.sv | 22 ++
 rtl/mac_pe_cell.sv | 63 ++++++
 rtl/mac_tile_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_mac_tile_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tile_pkg.sv
// -----------------------------------------------------------------------------
// mac_tile_pkg
// Shared definitions for the MAC tile engine: the default parameter values and
// the engine's control state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mac_tile_pkg;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_K_MAX      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        FLUSH  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/mac_pe_cell.sv
// -----------------------------------------------------------------------------
// mac_pe_cell
// One processing element of the output-stationary grid. When enabled, it
// multiplies the incoming operands, adds the product to its accumulator and
// forwards both operands to its right/lower neighbours through registers.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_en          shift operands and accumulate this cycle
//   i_clr         zero the accumulator (start of a fresh tile)
//   i_a, i_b      signed operands from the left / top neighbour
//   o_a, o_b      registered operands to the right / bottom neighbour
//   o_acc         accumulator value (wraps modulo 2^ACC_WIDTH)
// -----------------------------------------------------------------------------
module mac_pe_cell
    import mac_tile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [DATA_WIDTH-1:0]          r_a;
    logic [DATA_WIDTH-1:0]          r_b;
    logic [ACC_WIDTH-1:0]           r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]           w_prod_ext;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    // Sign-extend the full-precision product to accumulator width.
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (i_en) begin
                r_a <= i_a;
                r_b <= i_b;
            end
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/mac_tile_engine.sv
// -----------------------------------------------------------------------------
// mac_tile_engine
// Output-stationary systolic matrix-multiply tile. Each accepted beat carries
// column k of A and row k of B; skew registers delay row i / column j so that
// PE[i][j] sees beat k on its (k+i+j)-th enabled cycle. After cfg_k beats a
// zero-operand flush drains the skew, then C is read out one requantised row
// per handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a tile (IDLE only); samples all cfg_*
//   cfg_k                    number of operand beats
//   cfg_accumulate           keep accumulators from the previous tile
//   cfg_shift, cfg_sat_en    requantisation shift and saturate/wrap select
//   in_valid/in_ready        operand beat handshake; in_a, in_b operands
//   busy, done               tile in progress / one-cycle completion pulse
//   out_valid/out_ready      result row handshake
//   out_row_idx, out_data,   row index, requantised row, per-element
//   out_sat                  out-of-range flags
// -----------------------------------------------------------------------------
module mac_tile_engine
    import mac_tile_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int K_MAX      = DEF_K_MAX
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [$clog2(K_MAX+1)-1:0]            cfg_k,
    input  logic                                  cfg_accumulate,
    input  logic [$clog2(ACC_WIDTH)-1:0]          cfg_shift,
    input  logic                                  cfg_sat_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_a,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_b,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(ARRAY_SIZE)-1:0]         out_row_idx,
    output logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0]  out_data,
    output logic [ARRAY_SIZE-1:0]                 out_sat
);

    localparam int KW = $clog2(K_MAX+1);
    localparam int SW = $clog2(ACC_WIDTH);
    localparam int RW = $clog2(ARRAY_SIZE);
    localparam int FW = $clog2(2*ARRAY_SIZE);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2*ARRAY_SIZE-2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_SIZE-1);

    state_t          r_state, w_state_next;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   r_beat_cnt, w_beat_cnt_next;
    logic [FW-1:0]   r_flush_cnt, w_flush_cnt_next;
    logic [RW-1:0]   r_row, w_row_next;
    logic [SW-1:0]   r_shift;
    logic            r_sat_en;
    logic            r_done, w_done_next;
    logic            w_start_ok;
    logic            w_en;
    logic            w_clr;

    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_a_inj;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_b_inj;

    // Operand mesh: column ARRAY_SIZE of A and row ARRAY_SIZE of B are the
    // pass-through outputs of the last PEs and go nowhere.
    logic [DATA_WIDTH-1:0] w_a_mesh [ARRAY_SIZE][ARRAY_SIZE+1];
    logic [DATA_WIDTH-1:0] w_b_mesh [ARRAY_SIZE+1][ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]  w_acc    [ARRAY_SIZE][ARRAY_SIZE];

    // ---------------------------------------------------------------- control
    assign w_start_ok = (r_state == IDLE) && start;
    assign w_clr      = w_start_ok && !cfg_accumulate;
    // The grid only moves on accepted beats or while flushing; a FEED cycle
    // without in_valid freezes every PE and skew register.
    assign w_en       = ((r_state == FEED) && in_valid) || (r_state == FLUSH);
    assign w_a_inj    = (r_state == FEED) ? in_a : '0;
    assign w_b_inj    = (r_state == FEED) ? in_b : '0;

    always_comb begin
        w_state_next     = r_state;
        w_beat_cnt_next  = r_beat_cnt;
        w_flush_cnt_next = r_flush_cnt;
        w_row_next       = r_row;
        w_done_next      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_beat_cnt_next  = '0;
                    w_flush_cnt_next = '0;
                    w_row_next       = '0;
                    w_state_next     = (cfg_k == '0) ? FLUSH : FEED;
                end
            end
            FEED: begin
                if (in_valid) begin
                    if (r_beat_cnt == r_k - KW'(1)) begin
                        w_beat_cnt_next = '0;
                        w_state_next    = FLUSH;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + KW'(1);
                    end
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_flush_cnt_next = '0;
                    w_row_next       = '0;
                    w_state_next     = OUTPUT;
                end else begin
                    w_flush_cnt_next = r_flush_cnt + FW'(1);
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (r_row == ROW_LAST) begin
                        w_row_next   = '0;
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_row_next = r_row + RW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_row       <= '0;
            r_done      <= 1'b0;
            r_k         <= '0;
            r_shift     <= '0;
            r_sat_en    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_row       <= w_row_next;
            r_done      <= w_done_next;
            if (w_start_ok) begin
                r_k      <= cfg_k;
                r_shift  <= cfg_shift;
                r_sat_en <= cfg_sat_en;
            end
        end
    end

    // ----------------------------------------------------------- skew chains
    // Row i of A is delayed by i registers, column j of B by j registers.
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign w_a_mesh[0][0] = w_a_inj[0];
            assign w_b_mesh[0][0] = w_b_inj[0];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_a_sr [gi];
            logic [DATA_WIDTH-1:0] r_b_sr [gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_sr[s] <= '0;
                        r_b_sr[s] <= '0;
                    end
                end else if (w_en) begin
                    r_a_sr[0] <= w_a_inj[gi];
                    r_b_sr[0] <= w_b_inj[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_a_sr[s] <= r_a_sr[s-1];
                        r_b_sr[s] <= r_b_sr[s-1];
                    end
                end
            end
            assign w_a_mesh[gi][0] = r_a_sr[gi-1];
            assign w_b_mesh[0][gi] = r_b_sr[gi-1];
        end
    end

    // ------------------------------------------------------------- PE grid
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < ARRAY_SIZE; gj++) begin : g_col
            mac_pe_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .i_en  (w_en),
                .i_clr (w_clr),
                .i_a   (w_a_mesh[gi][gj]),
                .i_b   (w_b_mesh[gi][gj]),
                .o_a   (w_a_mesh[gi][gj+1]),
                .o_b   (w_b_mesh[gi+1][gj]),
                .o_acc (w_acc[gi][gj])
            );
        end
    end

    // ------------------------------------------------------- requantisation
    assign out_valid   = (r_state == OUTPUT);
    assign in_ready    = (r_state == FEED);
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign out_row_idx = r_row;

    for (genvar gj = 0; gj < ARRAY_SIZE; gj++) begin : g_quant
        logic signed [ACC_WIDTH-1:0]    w_shifted;
        logic [ACC_WIDTH-OUT_WIDTH:0]   w_top;
        logic                           w_in_range;
        logic [OUT_WIDTH-1:0]           w_clamped;
        logic [OUT_WIDTH-1:0]           w_res;

        assign w_shifted  = $signed(w_acc[r_row][gj]) >>> r_shift;
        // In range iff every bit from the output sign bit upward agrees.
        assign w_top      = w_shifted[ACC_WIDTH-1:OUT_WIDTH-1];
        assign w_in_range = (&w_top) | ~(|w_top);
        assign w_clamped  = w_shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        assign w_res      = (!w_in_range && r_sat_en) ? w_clamped
                                                      : w_shifted[OUT_WIDTH-1:0];
        // Outputs read as zero outside OUTPUT so idle/reset values are clean.
        assign out_data[gj] = out_valid ? w_res : '0;
        assign out_sat[gj]  = out_valid & ~w_in_range;
    end

endmodule

// File: tb/tb_mac_tile_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_tile_engine
// Directed bench for mac_tile_engine with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_mac_tile_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int KM = 16;
    localparam int KW = $clog2(KM+1);
    localparam int SW = $clog2(AW);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [KW-1:0]          cfg_k;
    logic                   cfg_accumulate;
    logic [SW-1:0]          cfg_shift;
    logic                   cfg_sat_en;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][DW-1:0]   in_a;
    logic [N-1:0][DW-1:0]   in_b;
    logic                   busy;
    logic                   done;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(N)-1:0]   out_row_idx;
    logic [N-1:0][OW-1:0]   out_data;
    logic [N-1:0]           out_sat;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    string cur_test = "reset";
    int    ma [N][N];      // ma[i][k]
    int    mb [N][N];      // mb[k][j]
    int    ec [N][N];      // expected requantised C
    bit [N-1:0] esat [N];  // expected out_sat per row
    int    lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mac_tile_engine #(
        .ARRAY_SIZE (N), .DATA_WIDTH (DW), .ACC_WIDTH (AW),
        .OUT_WIDTH (OW), .K_MAX (KM)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .cfg_k (cfg_k),
        .cfg_accumulate (cfg_accumulate), .cfg_shift (cfg_shift),
        .cfg_sat_en (cfg_sat_en), .in_valid (in_valid), .in_ready (in_ready),
        .in_a (in_a), .in_b (in_b), .busy (busy), .done (done),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_row_idx (out_row_idx), .out_data (out_data), .out_sat (out_sat)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ident_pattern();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4*i + j;
                ec[i][j] = 4*i + j;   // I*B = B
            end
        for (int r = 0; r < N; r++) esat[r] = '0;
    endtask

    task automatic set_const(input int v, input int e, input bit [N-1:0] s);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = v;
                mb[i][j] = v;
                ec[i][j] = e;
            end
        for (int r = 0; r < N; r++) esat[r] = s;
    endtask

    task automatic start_tile(input int k, input bit accum, input int sh, input bit sat);
        start          = 1'b1;
        cfg_k          = KW'(k);
        cfg_accumulate = accum;
        cfg_shift      = SW'(sh);
        cfg_sat_en     = sat;
        step();
        start = 1'b0;
        $display("start k=%0d accum=%0d shift=%0d sat=%0d", k, accum, sh, sat);
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
    endtask

    // Feed beats 0..k-1; gap idle cycles between beats; poke drives a
    // conflicting start/cfg during the gaps, which must be ignored.
    task automatic feed(input int k, input int gap, input bit poke);
        for (int kk = 0; kk < k; kk++) begin
            in_valid = 1'b1;
            for (int e = 0; e < N; e++) begin
                in_a[e] = DW'(ma[e][kk]);
                in_b[e] = DW'(mb[kk][e]);
            end
            chk("in_ready_feed", in_ready, 1);
            step();
            $display("beat %0d accepted", kk);
            in_valid = 1'b0;
            if (kk < k-1) begin
                for (int g = 0; g < gap; g++) begin
                    in_a = {N{8'h55}};
                    in_b = {N{8'h33}};
                    if (poke) begin
                        start          = 1'b1;
                        cfg_shift      = SW'(5);
                        cfg_accumulate = 1'b0;
                    end
                    step();
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic read_out(input int hold_row, input int hold_n, output int latency);
        int t0;
        int guard;
        logic [N-1:0][OW-1:0] er;
        guard = 0;
        while (!out_valid && guard < 40) begin
            step();
            guard++;
        end
        chk("out_valid_reached", out_valid, 1);
        t0 = cyc;
        for (int r = 0; r < N; r++) begin
            for (int e = 0; e < N; e++) er[e] = OW'(ec[r][e]);
            if (r == hold_row) begin
                out_ready = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_row_idx", out_row_idx, r);
                    chk("hold_data", out_data, er);
                    step();
                end
            end
            out_ready = 1'b1;
            chk("row_valid", out_valid, 1);
            chk("row_idx", out_row_idx, r);
            chk("row_data", out_data, er);
            chk("row_sat", out_sat, esat[r]);
            $display("row %0d data=%h sat=%b", r, out_data, out_sat);
            step();
        end
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        latency = cyc - t0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_accumulate = 1'b0;
        cfg_shift = '0; cfg_sat_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        step(); step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_row_idx", out_row_idx, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_out_data", out_data, 0);

        // Identity x B -> B, unstalled.
        cur_test = "ident";
        set_ident_pattern();
        start_tile(4, 0, 0, 1);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        chk("latency", lat, 4);
        step();
        chk("done_one_cycle", done, 0);

        // Same operands, valid pattern 1,0,0,1,...; stray start/cfg mid-tile.
        cur_test = "stall";
        start_tile(4, 0, 0, 1);
        feed(4, 2, 1);
        cfg_shift = '0;
        read_out(-1, 0, lat);
        step();

        // Sink back-pressure on row 1 for five cycles.
        cur_test = "hold";
        start_tile(4, 0, 0, 1);
        feed(4, 0, 0);
        read_out(1, 5, lat);
        chk("latency_held", lat, 9);
        step();

        // Two tiles of all ones, the second accumulating; second start lands
        // on the done cycle.
        cur_test = "accum1";
        set_const(1, 4, '0);
        start_tile(4, 0, 0, 1);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        cur_test = "accum2";
        set_const(1, 8, '0);
        start_tile(4, 1, 0, 1);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        step();

        // cfg_k=0 with accumulate: straight to flush, results unchanged.
        cur_test = "k0";
        start = 1'b1; cfg_k = '0; cfg_accumulate = 1'b1; cfg_shift = '0; cfg_sat_en = 1'b1;
        step();
        start = 1'b0;
        chk("k0_in_ready", in_ready, 0);
        chk("k0_busy", busy, 1);
        read_out(-1, 0, lat);
        step();

        // 127*127*4 = 64516, >>8 = 252: saturates to 127, wraps to -4.
        cur_test = "sat";
        set_const(127, 127, '1);
        start_tile(4, 0, 8, 1);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        step();
        cur_test = "wrap";
        set_const(127, -4, '1);
        start_tile(4, 0, 8, 0);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        step();

        // Reset on the second FEED beat, then an accumulating tile.
        cur_test = "midrst";
        set_const(127, 0, '0);
        start_tile(4, 0, 0, 1);
        in_valid = 1'b1;
        in_a = {N{8'd127}};
        in_b = {N{8'd127}};
        step();
        rst = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("midrst_idle_busy", busy, 0);
        set_ident_pattern();
        start_tile(4, 1, 0, 1);
        feed(4, 0, 0);
        read_out(-1, 0, lat);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
